// File: rtl/ahb_gpio.sv
// ahb_gpio: zero-wait-state AHB-Lite slave exposing a 16-bit GPIO port with a
// generated output parity bit and a checked input parity bit.
//
// Ports
//   HCLK, HRESET             bus clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS,     AHB-Lite address phase (only HADDR[7:0] decoded)
//   HWRITE, HREADY
//   HWDATA                   write data (data phase)
//   HRDATA, HREADYOUT        read data (combinational from the latched
//                            address phase), ready (always 1)
//   GPIOIN  [16:0]           [15:0] pad input data, [16] pad input parity
//   GPIOOUT [16:0]           [15:0] output data, [16] generated parity
//   PARITYSEL                0 = even parity, 1 = odd parity
//   PARITYERR                registered input parity mismatch (level)
//
// Register map (HADDR[7:0])
//   0x00 DATA  output value when DIR=1, sampled input when DIR=0
//   0x04 DIR   bit0: 1 = output mode, 0 = input mode
module ahb_gpio (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic        HREADY,
   output logic        HREADYOUT,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   input  logic [16:0] GPIOIN,
   output logic [16:0] GPIOOUT,
   output logic        PARITYERR,
   input  logic        PARITYSEL
);

   localparam int unsigned AW       = 8;
   localparam int unsigned GW       = 16;
   localparam logic [AW-1:0] ADDR_DATA = 8'h00;
   localparam logic [AW-1:0] ADDR_DIR  = 8'h04;

   // Latched address phase
   logic [AW-1:0] addr_q, addr_d;
   logic          write_q, write_d;
   logic          valid_q, valid_d;

   // Architectural state
   logic          dir_q, dir_d;
   logic [GW-1:0] dout_q, dout_d;
   logic [GW-1:0] din_q, din_d;
   logic          perr_q, perr_d;

   logic          addr_phase_c;
   logic          wr_en_c;
   logic          rd_en_c;
   logic          in_par_err_c;

   // Upper address/data bits and HTRANS[0] carry no meaning for this slave.
   logic          unused_bits;
   assign unused_bits = ^{HADDR[31:AW], HWDATA[31:GW], HTRANS[0]};

   assign addr_phase_c = HSEL & HREADY & HTRANS[1];
   assign wr_en_c      = valid_q & write_q;
   assign rd_en_c      = valid_q & ~write_q;

   // Parity of the pad word against its parity bit under the selected mode
   assign in_par_err_c = ((^GPIOIN[GW-1:0]) ^ PARITYSEL) != GPIOIN[GW];

   // Address-phase capture
   always_comb begin
      addr_d  = addr_q;
      write_d = write_q;
      valid_d = 1'b0;
      if (addr_phase_c) begin
         addr_d  = HADDR[AW-1:0];
         write_d = HWRITE;
         valid_d = 1'b1;
      end
   end

   // Data-phase register writes and input sampling
   always_comb begin
      dir_d  = dir_q;
      dout_d = dout_q;
      din_d  = din_q;
      perr_d = 1'b0;

      if (wr_en_c) begin
         if (addr_q == ADDR_DIR) begin
            dir_d = HWDATA[0];
         end
         // DATA writes only land in output mode; in input mode DATA mirrors pads.
         if ((addr_q == ADDR_DATA) && dir_q) begin
            dout_d = HWDATA[GW-1:0];
         end
      end

      // Sampling follows the committed DIR, so a 1->0 switch resumes next cycle.
      if (!dir_q) begin
         din_d  = GPIOIN[GW-1:0];
         perr_d = in_par_err_c;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         valid_q <= 1'b0;
         dir_q   <= 1'b0;
         dout_q  <= '0;
         din_q   <= '0;
         perr_q  <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         write_q <= write_d;
         valid_q <= valid_d;
         dir_q   <= dir_d;
         dout_q  <= dout_d;
         din_q   <= din_d;
         perr_q  <= perr_d;
      end
   end

   // Read mux driven from the latched address phase (zero wait states)
   always_comb begin
      HRDATA = '0;
      if (rd_en_c) begin
         unique case (addr_q)
            ADDR_DATA: HRDATA = {16'h0, (dir_q ? dout_q : din_q)};
            ADDR_DIR:  HRDATA = {31'h0, dir_q};
            default:   HRDATA = '0;
         endcase
      end
   end

   // Output parity tracks PARITYSEL immediately so pads always carry a
   // consistent word.
   assign GPIOOUT   = {(^dout_q) ^ PARITYSEL, dout_q};
   assign PARITYERR = perr_q;
   assign HREADYOUT = 1'b1;

endmodule

// File: tb/tb_ahb_gpio.sv
// Directed self-checking bench for ahb_gpio. Inputs are driven on the falling
// edge and outputs are observed on the falling edge, away from HCLK rising.
module tb_ahb_gpio;

   logic        HCLK;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic [16:0] GPIOIN;
   logic [16:0] GPIOOUT;
   logic        PARITYERR;
   logic        PARITYSEL;

   logic        loop_en;
   logic [16:0] gin_drv;

   int          total;
   int          bad;

   assign GPIOIN = loop_en ? GPIOOUT : gin_drv;

   ahb_gpio dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .GPIOIN    (GPIOIN),
      .GPIOOUT   (GPIOOUT),
      .PARITYERR (PARITYERR),
      .PARITYSEL (PARITYSEL)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HADDR  = 32'h0;
   endtask

   // Address phase, then data phase; returns on the falling edge after commit.
   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge HCLK);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b1;
      HADDR  = {24'h0, a};
      @(negedge HCLK);
      idle();
      HWDATA = d;
      @(negedge HCLK);
   endtask

   // Address phase, then sample HRDATA during the data phase.
   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge HCLK);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b0;
      HADDR  = {24'h0, a};
      @(negedge HCLK);
      d = HRDATA;
      idle();
   endtask

   initial begin
      logic [31:0] rd;
      logic [15:0] v;

      total     = 0;
      bad       = 0;
      loop_en   = 1'b0;
      gin_drv   = 17'h0;
      PARITYSEL = 1'b0;
      HREADY    = 1'b1;
      HWDATA    = 32'h0;
      idle();
      HRESET    = 1'b1;

      // Reset state
      repeat (2) @(negedge HCLK);
      check("rst_hrdata", HRDATA, 32'h0);
      check("rst_gpioout_even", {15'h0, GPIOOUT}, 32'h00000);
      check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      check("rst_parityerr", {31'h0, PARITYERR}, 32'h0);
      PARITYSEL = 1'b1;
      #1;
      check("rst_gpioout_odd", {15'h0, GPIOOUT}, 32'h10000);
      PARITYSEL = 1'b0;
      @(negedge HCLK);
      HRESET = 1'b0;

      // Output mode, DATA=A5A5, even parity
      bus_write(8'h04, 32'h1);
      bus_write(8'h00, 32'h0000A5A5);
      check("out_a5a5", {15'h0, GPIOOUT}, 32'h0A5A5);
      bus_read(8'h00, rd);
      check("rd_data_a5a5", rd, 32'h0000A5A5);
      bus_read(8'h04, rd);
      check("rd_dir_1", rd, 32'h1);
      check("perr_out_mode", {31'h0, PARITYERR}, 32'h0);

      // Parity bit follows PARITYSEL
      bus_write(8'h00, 32'h00000001);
      PARITYSEL = 1'b1;
      #1;
      check("out_0001_odd", {15'h0, GPIOOUT}, 32'h00001);
      PARITYSEL = 1'b0;
      #1;
      check("out_0001_even", {15'h0, GPIOOUT}, 32'h10001);

      // Write immediately followed by a read of the same register
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
      @(negedge HCLK);
      HWDATA = 32'h00005A5A;
      HWRITE = 1'b0;
      @(negedge HCLK);
      check("b2b_rd_after_wr", HRDATA, 32'h00005A5A);
      idle();
      bus_write(8'h00, 32'h00000001);

      // Input mode with a bad then good parity bit
      bus_write(8'h04, 32'h0);
      gin_drv = 17'h01234;
      bus_read(8'h00, rd);
      check("rd_din_1234", rd, 32'h00001234);
      check("perr_bad", {31'h0, PARITYERR}, 32'h1);
      gin_drv = 17'h11234;
      @(negedge HCLK);
      check("perr_good", {31'h0, PARITYERR}, 32'h0);

      // DATA write ignored in input mode; unmapped offset ignored
      bus_write(8'h00, 32'h0000FFFF);
      check("in_mode_wr_ignored", {15'h0, GPIOOUT}, 32'h10001);
      bus_write(8'h08, 32'hFFFFFFFF);
      bus_read(8'h08, rd);
      check("rd_unmapped", rd, 32'h0);
      bus_read(8'h04, rd);
      check("dir_still_0", rd, 32'h0);
      check("unmapped_no_out", {15'h0, GPIOOUT}, 32'h10001);

      // Loopback
      loop_en = 1'b1;
      bus_write(8'h04, 32'h1);
      v = 16'h0;
      for (int i = 0; i < 20; i++) begin
         v = 16'($urandom);
         bus_write(8'h00, {16'hDEAD, v});
         bus_read(8'h00, rd);
         check($sformatf("loop_rd_%0d", i), rd, {16'h0, v});
         check($sformatf("loop_pin_%0d", i), {16'h0, GPIOOUT[15:0]}, {16'h0, v});
      end
      bus_write(8'h04, 32'h0);
      bus_read(8'h00, rd);
      check("loop_din_last", rd, {16'h0, v});
      check("loop_perr_even", {31'h0, PARITYERR}, 32'h0);
      PARITYSEL = 1'b1;
      repeat (2) @(negedge HCLK);
      check("loop_perr_odd", {31'h0, PARITYERR}, 32'h0);
      PARITYSEL = 1'b0;
      loop_en   = 1'b0;
      gin_drv   = 17'h0;

      // Reset during a pending write data phase drops the write
      bus_write(8'h04, 32'h1);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
      @(negedge HCLK);
      idle();
      HWDATA = 32'h0000BEEF;
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      @(negedge HCLK);
      check("midrst_gpioout", {15'h0, GPIOOUT}, 32'h0);
      bus_read(8'h04, rd);
      check("midrst_dir", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
